// File: rtl/memory_pkg.sv
// Shared widths, FSM state encoding and the EX/MEM register layout for memory_stage.
package memory_pkg;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;
  localparam int REG_W  = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } mem_state_t;

  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic              mem_to_reg;
    logic              mem_read;
    logic              mem_write;
    logic              branch;
    logic              zero;
    logic [REG_W-1:0]  rd;
    logic [ADDR_W-1:0] pc_branch;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] write_data;
  } ex_mem_t;

endpackage

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: loads the execute bundle when enabled, clears on reset.
module ex_mem_reg
  import memory_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    en,
  input  ex_mem_t d,
  output ex_mem_t q
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/memory_stage.sv
// Memory pipeline stage: EX/MEM register, req/ack data-memory access FSM, branch resolve.
// Optional build macro MEM_TIMEOUT_EN adds an access timeout with a sticky fault flag.
module memory_stage #(
  parameter int ADDR_W         = memory_pkg::ADDR_W,
  parameter int DATA_W         = memory_pkg::DATA_W,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_E,
  input  logic              RegWrite_E,
  input  logic              MemtoReg_E,
  input  logic              MemRead_E,
  input  logic              MemWrite_E,
  input  logic              Branch_E,
  input  logic [4:0]        rd_E,
  input  logic [ADDR_W-1:0] PCBranch_E,
  input  logic [DATA_W-1:0] aluResult_E,
  input  logic [DATA_W-1:0] writeData_E,
  input  logic              zero_E,
  output logic              stall_M,
  output logic              PCSrc_M,
  output logic [ADDR_W-1:0] PCBranch_M,
  output logic              valid_M,
  output logic              RegWrite_M,
  output logic              MemtoReg_M,
  output logic [4:0]        rd_M,
  output logic [DATA_W-1:0] aluResult_M,
  output logic [DATA_W-1:0] readData_M,
  output logic              mem_fault_M,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack
);
  import memory_pkg::*;

  // The registered bundle has fixed package widths; reject mismatched overrides.
  if (ADDR_W != memory_pkg::ADDR_W || DATA_W != memory_pkg::DATA_W || TIMEOUT_CYCLES < 1)
  begin : g_bad_cfg
    $error("memory_stage: unsupported parameter combination");
  end

  ex_mem_t           ex_d, ex_q;
  mem_state_t        state_q, state_d;
  logic              stall;
  logic              is_load;
  logic              timeout;
  logic [DATA_W-1:0] read_data_q;
  logic              fault_q;

  assign stall   = (state_q == REQ);
  assign is_load = ex_q.mem_read & ~ex_q.mem_write;

  // Bubbles enter the register with every control bit cleared.
  always_comb begin
    ex_d            = '0;
    ex_d.valid      = valid_E;
    ex_d.reg_write  = valid_E & RegWrite_E;
    ex_d.mem_to_reg = valid_E & MemtoReg_E;
    ex_d.mem_read   = valid_E & MemRead_E;
    ex_d.mem_write  = valid_E & MemWrite_E;
    ex_d.branch     = valid_E & Branch_E;
    ex_d.zero       = zero_E;
    ex_d.rd         = rd_E;
    ex_d.pc_branch  = PCBranch_E;
    ex_d.alu_result = aluResult_E;
    ex_d.write_data = writeData_E;
  end

  ex_mem_reg u_ex_mem (
    .clk   (clk),
    .rst_n (reset),
    .en    (~stall),
    .d     (ex_d),
    .q     (ex_q)
  );

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES) > 0) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wait_cnt_q;

  // Held at zero outside REQ so every access starts counting from zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt_q <= '0;
    end else if (!stall) begin
      wait_cnt_q <= '0;
    end else if (!dmem_ack) begin
      wait_cnt_q <= wait_cnt_q + 1'b1;
    end
  end

  assign timeout = stall & ~dmem_ack & (wait_cnt_q == CNT_LAST);
`else
  assign timeout = 1'b0;
`endif

  // NOTE: next-state gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      REQ:     if (dmem_ack || timeout) state_d = RESP;
      default: state_d = (valid_E & (MemRead_E | MemWrite_E)) ? REQ : IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Ack beats timeout on the same cycle; a timed-out load returns zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      read_data_q <= '0;
      fault_q     <= 1'b0;
    end else if (stall) begin
      if (dmem_ack) begin
        if (is_load) read_data_q <= dmem_rdata;
      end else if (timeout) begin
        fault_q <= 1'b1;
        if (is_load) read_data_q <= '0;
      end
    end
  end

  assign stall_M     = stall;
  assign valid_M     = ex_q.valid & ~stall;
  assign PCSrc_M     = ex_q.valid & ex_q.branch & ex_q.zero;
  assign PCBranch_M  = ex_q.pc_branch;
  assign RegWrite_M  = ex_q.reg_write;
  assign MemtoReg_M  = ex_q.mem_to_reg;
  assign rd_M        = ex_q.rd;
  assign aluResult_M = ex_q.alu_result;
  assign readData_M  = read_data_q;
  assign mem_fault_M = fault_q;

  assign dmem_req    = stall;
  assign dmem_we     = stall & ex_q.mem_write;
  assign dmem_addr   = stall ? ex_q.alu_result : '0;
  assign dmem_wdata  = stall ? ex_q.write_data : '0;

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- Pipeline stage directly downstream of execute; owns the EX/MEM pipeline register, drives the data-memory bus, and resolves the branch decision.
- Captures execute results and issues LDUR/STUR accesses over a req/ack data-memory handshake. Stalls upstream while an access is outstanding.
- Presents results to writeback.

Parameters:
- ADDR_W, 64, data-memory address width.
- DATA_W, 64, data and ALU result width.
- TIMEOUT_CYCLES, 16, cycles allowed for dmem_ack; used only with MEM_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- valid_E  in  1  execute holds a real instruction (not a bubble).
- RegWrite_E, MemtoReg_E, MemRead_E, MemWrite_E, Branch_E  in  1 each  control bits from execute.
- rd_E  in  5  destination register.
- PCBranch_E  in  64  branch target.
- aluResult_E  in  64  ALU result / memory address.
- writeData_E  in  64  store data.
- zero_E  in  1  ALU zero flag.
- stall_M  out  1  freeze upstream stages this cycle.
- PCSrc_M  out  1  take branch.
- PCBranch_M  out  64  registered branch target.
- valid_M  out  1  result ready for writeback.
- RegWrite_M, MemtoReg_M  out  1 each  forwarded controls.
- rd_M  out  5  forwarded destination.
- aluResult_M  out  64  registered ALU result.
- readData_M  out  64  load data.
- mem_fault_M  out  1  memory timeout fault (sticky).
- dmem_req  out  1  access request.
- dmem_we  out  1  write enable.
- dmem_addr  out  64  access address.
- dmem_wdata  out  64  store data.
- dmem_rdata  in  64  load data, valid with dmem_ack.
- dmem_ack  in  1  access complete.

Behaviour:
- Reset (async, active-low): all registered outputs 0, state IDLE. dmem_req drops immediately, including mid-access. The aborted access is not retried.
- FSM states:
  - IDLE: no instruction, or a non-memory instruction held.
  - REQ: access outstanding.
  - RESP: access finished, result held.
- stall_M = (state==REQ), combinational.
- EX/MEM register loads all *_E inputs on the rising edge when stall_M=0. It holds while stall_M=1.
- Capture-edge transition from IDLE or RESP: next state is REQ if valid_E & (MemRead_E|MemWrite_E), else IDLE.
- While in REQ:
  - dmem_req=1; dmem_addr=aluResult_M; dmem_we=MemWrite_M; dmem_wdata=writeData held.
  - Outside REQ, dmem_req/dmem_we=0 and dmem_addr/dmem_wdata=0.
- On rising edge in REQ with dmem_ack=1:
  - Go to RESP.
  - If MemRead_M, readData_M <= dmem_rdata. readData_M is otherwise unchanged.
- dmem_ack outside REQ is ignored.
- Minimum memory-op occupancy is 2 cycles (ack in first REQ cycle). Each ack-free REQ cycle adds one.
- valid_M = valid_q & (state!=REQ). A non-memory op is valid the cycle after capture (latency 1).
- PCSrc_M = valid_q & Branch_M & zero_q, independent of state. Branches never access memory.
- MemRead_M & MemWrite_M both 1 is treated as a write.
- Bubble (valid_E=0) captures with all controls forced to 0.
- Back-to-back memory ops: RESP leaves on the same edge that captures the next op, so no idle cycle is inserted.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Enabled:
  - A counter increments each REQ cycle without ack and clears on REQ entry.
  - When the counter reaches TIMEOUT_CYCLES-1 without ack, the FSM goes to RESP and sets mem_fault_M=1, sticky until reset.
  - On a timed-out load, readData_M <= 0.
  - Ack on the timeout cycle wins, with no fault.
- Disabled: no counter; REQ waits indefinitely; mem_fault_M tied 0. The port always exists.

Decomposition:
- Package memory_pkg:
  - State enum mem_state_t {IDLE, REQ, RESP}.
  - Width constants ADDR_W/DATA_W/REG_W=5.
  - Struct ex_mem_t bundling the registered fields.
- Sub-module ex_mem_reg: enabled, async-reset pipeline register of ex_mem_t.
- FSM and bus drive stay in memory_stage.

Test Plan:
- Reset: drive reset=0 mid-REQ with aluResult_E=0x40 → dmem_req=0 same cycle; all outputs 0; state IDLE after release.
- ADD pass-through: valid_E=1, RegWrite_E=1, rd_E=3, aluResult_E=0x1234 → next cycle valid_M=1, aluResult_M=0x1234, rd_M=3, stall_M=0, dmem_req=0.
- LDUR, ack after 3 wait cycles: aluResult_E=0x80, dmem_rdata=0xDEADBEEF → dmem_req=1 with addr 0x80 and we=0; stall_M=1 for 4 cycles; readData_M=0xDEADBEEF; valid_M=1 in RESP.
- STUR, back-to-back with following LDUR, immediate acks: writeData_E=0x55 → dmem_we=1, wdata=0x55 for one cycle; LDUR captured on RESP edge with no gap.
- CBZ taken: Branch_E=1, zero_E=1, PCBranch_E=0x200 → PCSrc_M=1, PCBranch_M=0x200. With zero_E=0 → PCSrc_M=0.
- MEM_TIMEOUT_EN, no ack: LDUR held in REQ → after 16 REQ cycles, state RESP, mem_fault_M=1, readData_M=0, stall_M released.
